load_sel: RTL and testbench
===========================

Name: load_sel

Overview:
- Load-side counterpart of the data-RAM store byte-enable logic in the MEM stage.
- Accepts a load (LB/LBU/LH/LHU/LW) from the MEM stage and issues a read on the req/addr_ok/data_ok data-SRAM bus.
- Stalls the pipeline until read data returns, then extracts, aligns and sign/zero-extends the addressed byte, halfword or word for write-back.
- Aborts cleanly on exception or flush, including mid-transaction.

Parameters:
- ADDR_W, 32, data bus address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- opM  in  6  MEM-stage opcode (`op_LB/`op_LH/`op_LW/`op_LBU/`op_LHU from defines.vh; others = not a load).
- aluoutM  in  32  load effective address.
- excepttypeM  in  32  nonzero = exception pending in MEM; the load must not issue.
- flushM  in  1  pipeline flush; cancels the current load.
- data_req  out  1  bus read request.
- data_addr  out  ADDR_W  bus address (latched aluoutM).
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr_ok  in  1  request accepted this cycle.
- data_data_ok  in  1  read data valid this cycle.
- data_rdata  in  32  raw word from bus.
- readdataM  out  32  aligned/extended load result.
- load_done  out  1  one-cycle pulse; readdataM valid.
- stallM  out  1  freeze pipeline at and before MEM.

Behaviour:
- Clocking: clk only; reset is asynchronous active-low on resetn.
- Reset values: state = IDLE, data_req = 0, data_addr = 0, data_size = 0, readdataM = 0, load_done = 0. Internal op/offset registers clear to 0.
- Load start condition (start): opM is a load AND excepttypeM == 0 AND flushM == 0.
- IDLE:
  - On start: latch opM, aluoutM and size, go to REQ.
  - stallM = 1 combinationally in this cycle.
- REQ:
  - data_req = 1; data_addr and data_size come from the latch.
  - data_addr_ok → WAIT.
  - flushM with no addr_ok → IDLE, no request issued.
  - flushM together with addr_ok → CANCEL.
- WAIT:
  - data_data_ok → capture the extracted result into readdataM, go to DONE.
  - flushM → CANCEL, or IDLE if data_ok arrives in the same cycle (data discarded).
- CANCEL:
  - data_req = 0; wait for data_data_ok, discard the data, go to IDLE.
  - stallM = 0, because the flush already redirects the pipe.
  - A new start in CANCEL is held off by asserting stallM until CANCEL exits.
- DONE:
  - load_done = 1 for exactly one cycle; stallM = 0; go to IDLE.
  - A start in this cycle is not accepted; the pipe advances first.
- stallM = 1 in:
  - IDLE when start;
  - REQ and WAIT, unless flushM;
  - CANCEL when a load is presented.
- Bus rules:
  - data_data_ok never arrives in the same cycle as its data_addr_ok; it comes 1 or more cycles later.
  - At most one outstanding read.
  - data_req stays high until addr_ok.
- Minimum latency: start → load_done is 3 cycles when addr_ok is immediate and data_ok comes the next cycle.
- Extraction uses the latched address bits a = addr[1:0]:
  - LB/LBU: byte a (0 = bits 7:0 … 3 = bits 31:24), sign- or zero-extended.
  - LH/LHU: a[1] = 0 → bits 15:0, a[1] = 1 → bits 31:16, sign- or zero-extended.
  - LW: whole word.
- Misaligned addresses are flagged upstream via excepttypeM. With a nonzero excepttypeM the load never issues and stallM = 0.
- resetn asserted mid-transaction forces IDLE immediately. The bus side is reset by the same resetn, so no orphan data_ok is expected.
- readdataM holds its value until the next captured load.

Test Plan:
- LW at 0x1000, addr_ok in REQ, data_ok next cycle with rdata 0xDEADBEEF:
  - data_addr = 0x1000, size = 2;
  - load_done pulses 3 cycles after start; readdataM = 0xDEADBEEF;
  - stallM high for exactly 3 cycles.
- LB at 0x1003, rdata 0x80FF7F01 → readdataM = 0xFFFFFF80. LBU at the same address → 0x00000080. LB at 0x1000 → 0x00000001.
- LH at 0x1002, rdata 0x8001ABCD → 0xFFFF8001. LHU at 0x1000 → 0x0000ABCD.
- Flush in WAIT, then data_ok with 0x12345678 two cycles later:
  - state passes through CANCEL;
  - load_done never pulses; readdataM keeps its prior value;
  - a next LW presented during CANCEL stalls and issues only after the discard.
- LW with excepttypeM = 0x4 → data_req stays 0, stallM = 0, load_done = 0. An SW opcode likewise produces no request.
- addr_ok delayed 4 cycles and data_ok 3 cycles after that:
  - data_req held for 5 cycles with a stable address;
  - stallM continuous until DONE.
- resetn pulsed low in WAIT → all outputs return to reset values asynchronously; a fresh LW then completes normally.

Source files
------------

// File: rtl/load_sel_if.sv
// ---------------------------------------------------------------------------
// load_sel_if
// Data-SRAM read bus used by the MEM-stage load unit (req/addr_ok/data_ok
// handshake).
//
// Signals:
//   data_req      master->slave  read request, held until data_addr_ok
//   data_addr     master->slave  read address (ADDR_W bits)
//   data_size     master->slave  0 = byte, 1 = half, 2 = word
//   data_addr_ok  slave->master  request accepted this cycle
//   data_data_ok  slave->master  read data valid this cycle
//   data_rdata    slave->master  raw 32-bit read word
// ---------------------------------------------------------------------------
interface load_sel_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic [ADDR_W-1:0] data_addr;
    logic [1:0]        data_size;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req,
        output data_addr,
        output data_size,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_addr,
        input  data_size,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

// File: rtl/load_sel.sv
// ---------------------------------------------------------------------------
// load_sel
// MEM-stage load unit. Accepts LB/LBU/LH/LHU/LW, issues one read on the
// data-SRAM bus, stalls the pipe until the data returns, then aligns and
// sign/zero-extends the addressed byte/halfword/word. A flush or pending
// exception aborts the load, including mid-transaction.
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   opM          in   MEM-stage opcode
//   aluoutM      in   load effective address
//   excepttypeM  in   nonzero = exception pending, load must not issue
//   flushM       in   pipeline flush, cancels the current load
//   bus          --   data-SRAM read bus (master side)
//   readdataM    out  aligned/extended load result, held until next load
//   load_done    out  one-cycle pulse, readdataM valid
//   stallM       out  freeze pipeline at and before MEM
//
// ADDR_W must not exceed 32 (the address is taken from aluoutM).
// ---------------------------------------------------------------------------
module load_sel #(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  opM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] excepttypeM,
    input  logic        flushM,
    load_sel_if.master  bus,
    output logic [31:0] readdataM,
    output logic        load_done,
    output logic        stallM
);
    // MIPS load opcodes (same encodings as defines.vh)
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_CANCEL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [5:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_readdata;

    logic              w_is_load;
    logic              w_start;
    logic [1:0]        w_size;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;

    assign w_is_load = (opM == OP_LB) || (opM == OP_LBU) || (opM == OP_LH) ||
                       (opM == OP_LHU) || (opM == OP_LW);
    assign w_start   = w_is_load && (excepttypeM == 32'd0) && !flushM;

    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_size = 2'd2;
        if (opM == OP_LB || opM == OP_LBU) w_size = 2'd0;
        else if (opM == OP_LH || opM == OP_LHU) w_size = 2'd1;
    end

    // Next state and stall. A flush already redirects the pipe, so stallM
    // drops whenever flushM is seen mid-load; CANCEL only stalls to hold off
    // a new load until the orphaned read data has drained.
    always_comb begin
        w_next = r_state;
        stallM = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_REQ;
                    stallM = 1'b1;
                end
            end
            S_REQ: begin
                if (flushM) begin
                    w_next = bus.data_addr_ok ? S_CANCEL : S_IDLE;
                end else begin
                    stallM = 1'b1;
                    if (bus.data_addr_ok) w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flushM) begin
                    // data arriving with the flush is simply dropped
                    w_next = bus.data_data_ok ? S_IDLE : S_CANCEL;
                end else begin
                    stallM = 1'b1;
                    if (bus.data_data_ok) w_next = S_DONE;
                end
            end
            S_CANCEL: begin
                stallM = w_start;
                if (bus.data_data_ok) w_next = S_IDLE;
            end
            S_DONE:  w_next = S_IDLE;  // pipe advances before a new load
            default: w_next = S_IDLE;
        endcase
    end

    // Extraction from the latched op and low address bits.
    always_comb begin
        w_byte = bus.data_rdata[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = bus.data_rdata[15:8];
            2'd2:    w_byte = bus.data_rdata[23:16];
            2'd3:    w_byte = bus.data_rdata[31:24];
            default: w_byte = bus.data_rdata[7:0];
        endcase
        w_half = r_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (r_op)
            OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ext = {24'd0, w_byte};
            OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ext = {16'd0, w_half};
            default: w_ext = bus.data_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_op       <= 6'd0;
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_readdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_start) begin
                r_op   <= opM;
                r_addr <= aluoutM[ADDR_W-1:0];
                r_size <= w_size;
            end
            if (r_state == S_WAIT && bus.data_data_ok && !flushM) begin
                r_readdata <= w_ext;
            end
        end
    end

    assign bus.data_req  = (r_state == S_REQ);
    assign bus.data_addr = r_addr;
    assign bus.data_size = r_size;
    assign readdataM     = r_readdata;
    assign load_done     = (r_state == S_DONE);
endmodule

// File: tb/tb_load_sel.sv
// ---------------------------------------------------------------------------
// tb_load_sel
// Self-checking bench for load_sel. Inputs change just after the falling
// edge, outputs are sampled 1 ns later; the design clocks on the rising edge.
// The bench plays the data-SRAM slave itself with scripted handshake delays.
// ---------------------------------------------------------------------------
module tb_load_sel;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_NOP = 6'b000000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  opM;
    logic [31:0] aluoutM;
    logic [31:0] excepttypeM;
    logic        flushM;
    logic [31:0] readdataM;
    logic        load_done;
    logic        stallM;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata;  // model of readdataM (value of last completed load)

    load_sel_if #(.ADDR_W(32)) bus ();

    load_sel #(.ADDR_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .opM         (opM),
        .aluoutM     (aluoutM),
        .excepttypeM (excepttypeM),
        .flushM      (flushM),
        .bus         (bus.master),
        .readdataM   (readdataM),
        .load_done   (load_done),
        .stallM      (stallM)
    );

    always #5 clk = ~clk;

    // Reference: select by shifting, sign-extend by subtracting 2^n.
    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = 32'd0;
        if (op == OP_LW) begin
            v = rdata;
        end else if (op == OP_LB || op == OP_LBU) begin
            v = (rdata >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
            if (op == OP_LB && v >= 32'd128) v = v - 32'd256;
        end else if (op == OP_LH || op == OP_LHU) begin
            v = (rdata >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
            if (op == OP_LH && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [1:0] ref_size(input logic [5:0] op);
        if (op == OP_LB || op == OP_LBU) return 2'd0;
        if (op == OP_LH || op == OP_LHU) return 2'd1;
        return 2'd2;
    endfunction

    // One complete load: IDLE cycle, a_dly wait cycles then addr_ok in REQ,
    // data_ok d_dly (>=1) cycles later, then the DONE cycle.
    task automatic do_load(input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp_val,
                           input int a_dly, input int d_dly);
        int stalls;
        int req_cycles;
        stalls = 0;
        req_cycles = 0;
        @(negedge clk);
        opM = op; aluoutM = addr; excepttypeM = 32'd0; flushM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
        #1;
        if (stallM) stalls++;
        checks++;
        if (bus.data_req !== 1'b0) begin
            errors++; $display("FAIL idle_req: got %b want 0", bus.data_req);
        end
        for (int i = 0; i <= a_dly; i++) begin
            @(negedge clk);
            bus.data_addr_ok = (i == a_dly);
            aluoutM = $urandom;  // must not disturb the latched address
            #1;
            if (stallM) stalls++;
            if (bus.data_req) req_cycles++;
            checks++;
            if (bus.data_addr !== addr) begin
                errors++; $display("FAIL req_addr: got %h want %h", bus.data_addr, addr);
            end
            checks++;
            if (bus.data_size !== ref_size(op)) begin
                errors++; $display("FAIL req_size: got %0d want %0d", bus.data_size, ref_size(op));
            end
            checks++;
            if (load_done !== 1'b0 || readdataM !== exp_rdata) begin
                errors++; $display("FAIL req_hold: done %b rdata %h want 0 %h", load_done, readdataM, exp_rdata);
            end
        end
        for (int j = 1; j <= d_dly; j++) begin
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = (j == d_dly);
            bus.data_rdata = (j == d_dly) ? rdata : $urandom;
            #1;
            if (stallM) stalls++;
            if (bus.data_req) req_cycles++;
            checks++;
            if (load_done !== 1'b0 || readdataM !== exp_rdata) begin
                errors++; $display("FAIL wait_hold: done %b rdata %h want 0 %h", load_done, readdataM, exp_rdata);
            end
        end
        @(negedge clk);
        bus.data_data_ok = 1'b0;
        bus.data_rdata = $urandom;
        #1;
        checks++;
        if (load_done !== 1'b1 || stallM !== 1'b0) begin
            errors++; $display("FAIL done_pulse: done %b stall %b want 1 0", load_done, stallM);
        end
        checks++;
        if (readdataM !== exp_val) begin
            errors++; $display("FAIL result op=%b addr=%h: got %h want %h", op, addr, readdataM, exp_val);
        end
        checks++;
        if (stalls != 2 + a_dly + d_dly || req_cycles != a_dly + 1) begin
            errors++; $display("FAIL stall_len: stall %0d req %0d want %0d %0d",
                               stalls, req_cycles, 2 + a_dly + d_dly, a_dly + 1);
        end
        exp_rdata = exp_val;
        @(negedge clk);
        opM = OP_NOP;
        #1;
        checks++;
        if (load_done !== 1'b0 || stallM !== 1'b0 || bus.data_req !== 1'b0 || readdataM !== exp_rdata) begin
            errors++; $display("FAIL after_done: done %b stall %b req %b rdata %h want 0 0 0 %h",
                               load_done, stallM, bus.data_req, readdataM, exp_rdata);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; opM = OP_NOP; aluoutM = 32'd0; excepttypeM = 32'd0; flushM = 1'b0;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.data_req, bus.data_addr, bus.data_size, readdataM, load_done, stallM} !== 68'd0) begin
            errors++; $display("FAIL reset: req %b addr %h size %0d rdata %h done %b stall %b want all 0",
                               bus.data_req, bus.data_addr, bus.data_size, readdataM, load_done, stallM);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_rdata = 32'd0;
    endtask

    task automatic test_directed;
        do_load(OP_LW,  32'h0000_1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1);
        do_load(OP_LB,  32'h0000_1003, 32'h80FF_7F01, 32'hFFFF_FF80, 0, 1);
        do_load(OP_LBU, 32'h0000_1003, 32'h80FF_7F01, 32'h0000_0080, 0, 1);
        do_load(OP_LB,  32'h0000_1000, 32'h80FF_7F01, 32'h0000_0001, 0, 1);
        do_load(OP_LH,  32'h0000_1002, 32'h8001_ABCD, 32'hFFFF_8001, 0, 1);
        do_load(OP_LHU, 32'h0000_1000, 32'h8001_ABCD, 32'h0000_ABCD, 0, 1);
        do_load(OP_LW,  32'h0000_1234, 32'hCAFE_F00D, 32'hCAFE_F00D, 4, 3);  // slow bus
    endtask

    task automatic test_exception;
        logic [5:0] ops [2];
        logic [31:0] excs [2];
        ops[0] = OP_LW; excs[0] = 32'h4;
        ops[1] = OP_SW; excs[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                opM = ops[k]; aluoutM = 32'h0000_1000; excepttypeM = excs[k];
                #1;
                checks++;
                if (bus.data_req !== 1'b0 || stallM !== 1'b0 || load_done !== 1'b0) begin
                    errors++; $display("FAIL no_issue op=%b: req %b stall %b done %b want 0 0 0",
                                       ops[k], bus.data_req, stallM, load_done);
                end
            end
        end
        @(negedge clk);
        opM = OP_NOP; excepttypeM = 32'd0;
    endtask

    // Flush in WAIT, data_ok two cycles later, next LW held off during CANCEL.
    task automatic test_flush_wait;
        @(negedge clk);
        opM = OP_LW; aluoutM = 32'h0000_1100;
        #1;
        @(negedge clk);
        bus.data_addr_ok = 1'b1;
        #1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0; flushM = 1'b1;
        #1;
        checks++;
        if (stallM !== 1'b0 || bus.data_req !== 1'b0) begin
            errors++; $display("FAIL flush_wait: stall %b req %b want 0 0", stallM, bus.data_req);
        end
        @(negedge clk);
        flushM = 1'b0; opM = OP_NOP;
        #1;
        checks++;
        if (stallM !== 1'b0) begin
            errors++; $display("FAIL cancel_idle_stall: got %b want 0", stallM);
        end
        @(negedge clk);
        opM = OP_LW; aluoutM = 32'h0000_2000;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (stallM !== 1'b1 || bus.data_req !== 1'b0 || load_done !== 1'b0) begin
            errors++; $display("FAIL cancel_hold: stall %b req %b done %b want 1 0 0",
                               stallM, bus.data_req, load_done);
        end
        // discard done; the held LW now issues (readdataM must still be the old value)
        do_load(OP_LW, 32'h0000_2000, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 1);
    endtask

    // Flush in REQ with and without addr_ok, and flush together with data_ok.
    task automatic test_flush_edges;
        for (int mode = 0; mode < 3; mode++) begin
            @(negedge clk);
            opM = OP_LW; aluoutM = 32'h0000_3000;
            #1;
            @(negedge clk);  // REQ
            flushM = (mode != 2);
            bus.data_addr_ok = (mode != 0);
            #1;
            checks++;
            if (stallM !== (mode == 2)) begin
                errors++; $display("FAIL flush_req mode %0d: stall %b want %b", mode, stallM, mode == 2);
            end
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            flushM = (mode == 2);
            bus.data_data_ok = (mode == 2);
            bus.data_rdata = 32'h5555_AAAA;
            opM = (mode == 2) ? OP_LW : OP_NOP;
            #1;
            checks++;
            if (stallM !== 1'b0 || bus.data_req !== 1'b0) begin
                errors++; $display("FAIL flush_step mode %0d: stall %b req %b want 0 0", mode, stallM, bus.data_req);
            end
            @(negedge clk);
            flushM = 1'b0; opM = OP_NOP;
            bus.data_data_ok = (mode == 1);  // drain the orphan read
            #1;
            @(negedge clk);
            bus.data_data_ok = 1'b0;
            #1;
            checks++;
            if (load_done !== 1'b0 || bus.data_req !== 1'b0 || readdataM !== exp_rdata) begin
                errors++; $display("FAIL flush_end mode %0d: done %b req %b rdata %h want 0 0 %h",
                                   mode, load_done, bus.data_req, readdataM, exp_rdata);
            end
        end
    endtask

    task automatic test_random;
        logic [5:0]  ops [5];
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        ops[0] = OP_LB; ops[1] = OP_LBU; ops[2] = OP_LH; ops[3] = OP_LHU; ops[4] = OP_LW;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 4)];
            addr = $urandom;
            if (ref_size(op) == 2'd1) addr[0] = 1'b0;
            if (ref_size(op) == 2'd2) addr[1:0] = 2'b00;
            rdata = $urandom;
            do_load(op, addr, rdata, ref_load(op, addr, rdata),
                    $urandom_range(0, 3), $urandom_range(1, 3));
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        opM = OP_LW; aluoutM = 32'h0000_4000;
        #1;
        @(negedge clk);
        bus.data_addr_ok = 1'b1;
        #1;
        @(negedge clk);  // WAIT
        bus.data_addr_ok = 1'b0;
        #2;
        opM = OP_NOP;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.data_req, bus.data_addr, bus.data_size, readdataM, load_done, stallM} !== 68'd0) begin
            errors++; $display("FAIL reset_mid: req %b addr %h size %0d rdata %h done %b stall %b want all 0",
                               bus.data_req, bus.data_addr, bus.data_size, readdataM, load_done, stallM);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_rdata = 32'd0;
        do_load(OP_LW, 32'h0000_5004, 32'h600D_CAFE, 32'h600D_CAFE, 0, 1);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_exception;
        test_flush_wait;
        test_flush_edges;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
